// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the datapath arithmetic unit.
//   state_t     : sequencer state encoding used by booth_mult_seq
//                 (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
//   booth_op_t  : radix-2 Booth recode result (NOP / ADD / SUB).
//   booth_recode: maps the multiplier bit pair {Q[0], q_1} to a booth_op_t.
// -----------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // Radix-2 Booth recoding: a 0->1 transition (reading LSB first) starts a run
  // of ones and subtracts, a 1->0 transition ends the run and adds.
  function automatic booth_op_t booth_recode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_seq_addsub.sv
// -----------------------------------------------------------------------------
// nBitAddSub
// n-bit two's-complement adder/subtractor.
//   a    in  n : first operand
//   b    in  n : second operand
//   m    in  1 : mode, 0 = a + b, 1 = a - b (b inverted, carry-in 1)
//   sum  out n : result, modulo 2^n
//   cout out 1 : carry-out of the n-bit addition
// -----------------------------------------------------------------------------
module nBitAddSub #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         m,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n-1:0] b_eff_s;
  logic [n:0]   full_s;

  // Conditional inversion of b plus carry-in m yields a - b when m is set.
  always_comb begin
    b_eff_s = b ^ {n{m}};
    full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{n{1'b0}}, m};
    sum     = full_s[n-1:0];
    cout    = full_s[n];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential signed radix-2 Booth multiplier. One Booth step per clock using an
// (N+1)-bit nBitAddSub; an N x N two's-complement product takes N RUN cycles.
//   clk     in  1  : rising-edge clock
//   rst_n   in  1  : synchronous active-low reset
//   start   in  1  : request, accepted only in IDLE
//   a       in  N  : signed multiplicand, sampled on the accepting edge
//   b       in  N  : signed multiplier, sampled on the accepting edge
//   busy    out 1  : high while RUN or DONE
//   done    out 1  : one-cycle pulse in DONE
//   product out 2N : signed result, held until the next result is written
// -----------------------------------------------------------------------------
module booth_mult_seq
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  state_t         state_r;
  logic [N:0]     m_r;       // sign-extended multiplicand
  logic [N:0]     a_r;       // partial-product accumulator (A)
  logic [N-1:0]   q_r;       // multiplier / low product bits (Q)
  logic           q1_r;      // Booth history bit (q_1)
  logic [CW-1:0]  count_r;
  logic           busy_r;
  logic           done_r;
  logic [2*N-1:0] product_r;

  booth_op_t      op_s;
  logic           sub_s;
  logic [N:0]     sum_s;
  logic [N:0]     acc_s;     // A' : accumulator after the add/sub/pass step
  logic [N:0]     a_shift_s;
  logic [N-1:0]   q_shift_s;
  logic           cout_unused_s;

  // The adder is one bit wider than the operands so A - M cannot overflow
  // when a = -2^(N-1); its carry-out carries no information here.
  nBitAddSub #(
    .n(N + 1)
  ) u_addsub (
    .a   (a_r),
    .b   (m_r),
    .m   (sub_s),
    .sum (sum_s),
    .cout(cout_unused_s)
  );

  // Booth step: choose A+M, A-M or A, then arithmetic-shift {A', Q, q_1}.
  always_comb begin
    op_s  = booth_recode(q_r[0], q1_r);
    sub_s = 1'b0;
    acc_s = a_r;
    case (op_s)
      BOOTH_ADD: begin
        sub_s = 1'b0;
        acc_s = sum_s;
      end
      BOOTH_SUB: begin
        sub_s = 1'b1;
        acc_s = sum_s;
      end
      default: begin
        sub_s = 1'b0;
        acc_s = a_r;
      end
    endcase
    a_shift_s = {acc_s[N], acc_s[N:1]};
    q_shift_s = {acc_s[0], q_r[N-1:1]};
  end

  // Sequencer, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      m_r       <= {(N+1){1'b0}};
      a_r       <= {(N+1){1'b0}};
      q_r       <= {N{1'b0}};
      q1_r      <= 1'b0;
      count_r   <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            m_r     <= {a[N-1], a};
            a_r     <= {(N+1){1'b0}};
            q_r     <= b;
            q1_r    <= 1'b0;
            count_r <= CW'(N);
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_shift_s;
          q_r     <= q_shift_s;
          q1_r    <= q_r[0];
          count_r <= count_r - CW'(1);
          // Last step: the low 2N bits of the shifted {A', Q} are the product;
          // the extra accumulator MSB is only a sign guard.
          if (count_r == CW'(1)) begin
            product_r <= {a_shift_s[N-1:0], q_shift_s};
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            done_r    <= 1'b0;
            state_r   <= RUN;
          end
        end
        DONE: begin
          // start is ignored here; a request must be re-presented in IDLE.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Scoreboard bench for booth_mult_seq (N=4). Stimulus pushes the expected
// product and accept cycle into a queue; a monitor on the falling edge pops
// and checks whenever done is presented.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_len = 0;
  bit   prev_done = 1'b0;

  booth_mult_seq #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_len = busy_len + 1;
    else busy_len = 0;
    if (prev_done) chk("busy_fall", 64'(busy), 64'd0);
    if (done === 1'b1) begin
      if (prev_done) begin
        checks++;
        failures++;
        $display("FAIL done_pulse: done high for more than one cycle at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: product=%0h with nothing outstanding", product);
      end else begin
        e = q.pop_front();
        chk("product", 64'(product), 64'(e.prod));
        chk("latency", 64'(cyc), 64'(e.acc + N));
        chk("busy_len", 64'(busy_len), 64'(N + 1));
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Issue one request from a falling edge; returns at the falling edge after
  // the accepting edge with start low and the operands scrambled.
  task automatic run_mult(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic [2*N-1:0] p, input bit push);
    wait_idle();
    a = ta;
    b = tb_v;
    start = 1'b1;
    if (push) q.push_back('{prod: p, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
  endtask

  task automatic wait_queue(input int sz);
    int n = 0;
    while (q.size() > sz && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > sz) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d outstanding, required %0d", q.size(), sz);
    end
  endtask

  initial begin
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic [2*N-1:0] sp;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, hand-computed products
    run_mult(4'd3, 4'd5, 8'h0F, 1'b1);
    run_mult(4'hD, 4'd5, 8'hF1, 1'b1);
    run_mult(4'd7, 4'h8, 8'hC8, 1'b1);
    run_mult(4'h8, 4'h8, 8'h40, 1'b1);
    wait_queue(0);

    // start held high: second op only accepted at the IDLE edge after DONE
    wait_idle();
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    q.push_back('{prod: 8'h06, acc: cyc + 1});
    q.push_back('{prod: 8'h01, acc: cyc + 1 + N + 2});
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    wait_queue(0);
    start = 1'b0;

    // Reset at E2 of a 5 x 5 operation: abort, no done
    run_mult(4'd5, 4'd5, 8'h19, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    repeat (N + 2) @(negedge clk);
    chk("abort_product_hold", 64'(product), 64'd0);
    run_mult(4'd2, 4'hF, 8'hFE, 1'b1);
    wait_queue(0);

    // Exhaustive sweep against a behavioural signed multiply
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        sa = 4'(i);
        sb = 4'(j);
        sp = 8'(i * j);
        run_mult(sa, sb, sp, 1'b1);
      end
    end
    wait_queue(0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
